// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the PC sequencer: FSM states, PC-source mux
// selects and exception cause codes.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXC_SAVE,
        EXC_READ,
        EXC_WAIT,
        EXC_LOAD
    } state_t;

    localparam logic [2:0] PCSRC_ALU    = 3'b000;
    localparam logic [2:0] PCSRC_ALUOUT = 3'b001;
    localparam logic [2:0] PCSRC_JUMP   = 3'b010;
    localparam logic [2:0] PCSRC_EPC    = 3'b100;
    localparam logic [2:0] PCSRC_LOADSZ = 3'b110;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_OPCODE   = 2'd1;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'd2;
    localparam logic [1:0] CAUSE_DIV0     = 2'd3;

    localparam int CNT_W = 3;

endpackage

// File: rtl/pc_seq_ctrl_exc_wait_counter.sv
// Down-counter timing the vector-fetch memory latency. done_o flags the cycle
// in which a decrement brings the count to zero.
module exc_wait_counter
    import pc_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of 0 while waiting would stall forever; treat it as done as well.
    assign done_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC-source sequencer for the multicycle MIPS datapath with exception entry.
// Optional feature macro: PC_SEQ_ERET_EN (honour eret, drive the EPC select).
//
// state    | meaning
// IDLE     | normal PC update decode, sample exception flags
// EXC_SAVE | EPC <- pc_in - 4
// EXC_READ | strobe vector read for the latched cause, load wait counter
// EXC_WAIT | wait for memory latency to elapse
// EXC_LOAD | load handler address into PC through the load-size path
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int          MEM_LATENCY  = 2,
    parameter logic [31:0] VEC_OPCODE   = 32'd253,
    parameter logic [31:0] VEC_OVERFLOW = 32'd254,
    parameter logic [31:0] VEC_DIV0     = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        zero,
    input  logic        jump,
    input  logic        eret,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    output logic [2:0]  pc_source,
    output logic        pc_load,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        exc_mem_read,
    output logic [31:0] exc_mem_addr,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] vec_addr;
    logic        eret_req;
    logic        exc_any;
    logic        cnt_load, cnt_dec, cnt_done;

`ifdef PC_SEQ_ERET_EN
    assign eret_req = eret;
`else
    logic unused_eret;
    assign unused_eret = eret;
    assign eret_req    = 1'b0;
`endif

    assign exc_any = exc_opcode | exc_overflow | exc_div0;

    always_comb begin
        case (cause_q)
            CAUSE_OPCODE:   vec_addr = VEC_OPCODE;
            CAUSE_OVERFLOW: vec_addr = VEC_OVERFLOW;
            CAUSE_DIV0:     vec_addr = VEC_DIV0;
            default:        vec_addr = '0;
        endcase
    end

    exc_wait_counter u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(MEM_LATENCY - 1)),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        epc_d        = epc_q;
        pc_source    = PCSRC_ALU;
        pc_load      = 1'b0;
        exc_mem_read = 1'b0;
        exc_mem_addr = '0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                // Keep the decode quiet while reset is held so outputs read as zero.
                if (!reset) begin
                    pc_load = 1'b0;
                end else if (exc_any) begin
                    if (exc_opcode)        cause_d = CAUSE_OPCODE;
                    else if (exc_overflow) cause_d = CAUSE_OVERFLOW;
                    else                   cause_d = CAUSE_DIV0;
                    state_d = EXC_SAVE;
                end else if (eret_req) begin
                    pc_source = PCSRC_EPC;
                    pc_load   = 1'b1;
                end else if (jump) begin
                    pc_source = PCSRC_JUMP;
                    pc_load   = 1'b1;
                end else if ((branch_eq && zero) || (branch_ne && !zero)) begin
                    pc_source = PCSRC_ALUOUT;
                    pc_load   = 1'b1;
                end else if (pc_write) begin
                    pc_load = 1'b1;
                end
            end
            EXC_SAVE: begin
                epc_d   = pc_in - 32'd4;
                state_d = EXC_READ;
            end
            EXC_READ: begin
                exc_mem_read = 1'b1;
                exc_mem_addr = vec_addr;
                cnt_load     = 1'b1;
                state_d      = (MEM_LATENCY == 1) ? EXC_LOAD : EXC_WAIT;
            end
            EXC_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_done) state_d = EXC_LOAD;
            end
            EXC_LOAD: begin
                pc_source = PCSRC_LOADSZ;
                pc_load   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign epc   = epc_q;
    assign cause = cause_q;

endmodule
